// File: rtl/fetch_queue_if.sv
// Fetch-unit bus: instruction-memory request channel plus the IF/ID boundary.
// imem: the request is offered with imem_req and completes on a cycle with imem_req && imem_ack;
// once offered, imem_req and imem_addr hold until that cycle. IF/ID: the head moves on when
// out_valid && !stall.
interface fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc,
      input  imem_ack, imem_rdata, redirect, redirect_pc, stall
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc,
      output imem_ack, imem_rdata, redirect, redirect_pc, stall
   );
endinterface

// File: rtl/fetch_queue.sv
// IF-stage fetch unit: a PC generator that keeps one instruction-memory request outstanding
// and a DEPTH-entry FIFO of {pc, instr} that feeds the IF/ID boundary.
module fetch_queue #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic          clock,
   input  logic          reset,
   fetch_queue_if.master fq,
   output logic          dbgState
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {FETCH = 1'b0, DISCARD = 1'b1} state_t;

   state_t          state;
   logic [31:0]     pc;
   logic [31:0]     discardAddr;
   logic            pending;
   logic [PW-1:0]   rdPtr;
   logic [PW-1:0]   wrPtr;
   logic [CW-1:0]   count;
   logic [31:0]     instrMem [DEPTH];
   logic [31:0]     pcMem [DEPTH];

   logic            outValid;
   logic            pop;
   logic            push;
   logic            hasRoom;
   logic [CW-1:0]   countEff;

   assign outValid = (count != '0);
   assign pop      = outValid && !fq.stall && !fq.redirect;
   assign countEff = count - CW'(pop);
   assign hasRoom  = (countEff < CW'(DEPTH));
   assign push     = (state == FETCH) && fq.imem_req && fq.imem_ack && !fq.redirect;

   // A request already on the bus stays there until acked, even across a redirect.
   always_comb begin
      fq.imem_req  = 1'b0;
      fq.imem_addr = pc;
      if (!reset) begin
         fq.imem_req = 1'b0;
      end else if (state == DISCARD) begin
         fq.imem_req  = 1'b1;
         fq.imem_addr = discardAddr;
      end else begin
         fq.imem_req = pending || (hasRoom && !fq.redirect);
      end
   end

   assign fq.out_valid = outValid;
   assign fq.out_instr = outValid ? instrMem[rdPtr] : NOP_INSTR;
   assign fq.out_pc    = outValid ? pcMem[rdPtr] : 32'h0;
   assign dbgState     = state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         discardAddr <= 32'h0;
         pending     <= 1'b0;
         rdPtr       <= '0;
         wrPtr       <= '0;
         count       <= '0;
      end else begin
         case (state)
            FETCH: begin
               pending <= fq.imem_req && !fq.imem_ack;
               // The in-flight word belongs to the old stream; park on its address until it lands.
               if (fq.redirect && pending && !fq.imem_ack) begin
                  state       <= DISCARD;
                  discardAddr <= pc;
               end
            end
            DISCARD: begin
               if (fq.imem_ack) begin
                  state   <= FETCH;
                  pending <= 1'b0;
               end
            end
            default: state <= FETCH;
         endcase

         if (fq.redirect) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
            pc    <= {fq.redirect_pc[31:2], 2'b00};
         end else begin
            if (push) begin
               pc    <= pc + 32'd4;
               wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
               rdPtr <= rdPtr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         instrMem[wrPtr] <= fq.imem_rdata;
         pcMem[wrPtr]    <= pc;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a configurable-latency instruction memory returning
// 0x00100093+addr and hand-computed expectations at each step.
module tb_fetch_queue;
   logic clock;
   logic reset;
   logic dbgState;
   int   latency;
   int   waitCnt;
   int   checks;
   int   failures;
   logic [31:0] exp_q[$];

   fetch_queue_if bus ();

   fetch_queue dut (
      .clock    (clock),
      .reset    (reset),
      .fq       (bus.master),
      .dbgState (dbgState)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory model: acks once the request has waited `latency` cycles.
   always @(posedge clock or negedge reset) begin
      if (!reset) waitCnt <= 0;
      else if (bus.imem_req && !bus.imem_ack) waitCnt <= waitCnt + 1;
      else waitCnt <= 0;
   end
   assign bus.imem_ack   = bus.imem_req && (waitCnt >= latency);
   assign bus.imem_rdata = 32'h0010_0093 + bus.imem_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.stall = 1'b0;
      #1;
      chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
      chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("rst_instr", bus.out_instr, 32'h0000_0013);
      chk("rst_pc", bus.out_pc, 32'h0);
      tick();
      reset = 1'b1;
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      latency = 0;

      // Zero-wait streaming: one instruction per cycle from PC 0.
      do_reset();
      chk("t1_req", {31'b0, bus.imem_req}, 32'h1);
      chk("t1_addr0", bus.imem_addr, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_valid", {31'b0, bus.out_valid}, 32'h1);
         chk("t1_pc", bus.out_pc, 32'(4 * i));
         chk("t1_instr", bus.out_instr, 32'h0010_0093 + 32'(4 * i));
         chk("t1_addr", bus.imem_addr, 32'(4 * (i + 1)));
      end

      // Stall fills the FIFO, then drains in order and fetch resumes at 16.
      do_reset();
      bus.stall = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) tick();
      chk("t2_full_req", {31'b0, bus.imem_req}, 32'h0);
      chk("t2_head_pc", bus.out_pc, 32'h0);
      bus.stall = 1'b0;
      #1;
      chk("t2_resume_req", {31'b0, bus.imem_req}, 32'h1);
      chk("t2_resume_addr", bus.imem_addr, 32'h10);
      exp_q = {32'h4, 32'h8, 32'hC, 32'h10};
      while (exp_q.size() > 0) begin
         tick();
         chk("t2_pop_pc", bus.out_pc, exp_q.pop_front());
      end

      // Redirect with a pending latency-3 request: address held, word discarded.
      latency = 3;
      do_reset();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h20;
      #1;
      chk("t3_redir_req", {31'b0, bus.imem_req}, 32'h0);
      tick();
      bus.redirect = 1'b0;
      #1;
      chk("t3_addr20", bus.imem_addr, 32'h20);
      tick();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h103;
      #1;
      chk("t3_hold_req", {31'b0, bus.imem_req}, 32'h1);
      chk("t3_hold_addr", bus.imem_addr, 32'h20);
      tick();
      bus.redirect = 1'b0;
      #1;
      chk("t3_discard", {31'b0, dbgState}, 32'h1);
      chk("t3_disc_addr", bus.imem_addr, 32'h20);
      tick();
      chk("t3_ack_addr", bus.imem_addr, 32'h20);
      chk("t3_ack_seen", {31'b0, bus.imem_ack}, 32'h1);
      tick();
      chk("t3_fetch", {31'b0, dbgState}, 32'h0);
      chk("t3_new_addr", bus.imem_addr, 32'h100);
      chk("t3_no_push", {31'b0, bus.out_valid}, 32'h0);
      for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
      chk("t3_valid_timeout", {31'b0, bus.out_valid}, 32'h1);
      chk("t3_first_pc", bus.out_pc, 32'h100);
      chk("t3_first_instr", bus.out_instr, 32'h0010_0193);

      // Redirect in the ack cycle of the request to 0x8.
      latency = 1;
      do_reset();
      for (int k = 0; k < 20 && !(bus.imem_req && bus.imem_addr == 32'h8); k++) tick();
      chk("t4_found_addr8", bus.imem_addr, 32'h8);
      tick();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h40;
      #1;
      chk("t4_ack_cycle", {31'b0, bus.imem_ack}, 32'h1);
      tick();
      bus.redirect = 1'b0;
      #1;
      chk("t4_empty", {31'b0, bus.out_valid}, 32'h0);
      chk("t4_nop", bus.out_instr, 32'h0000_0013);
      chk("t4_pc0", bus.out_pc, 32'h0);
      chk("t4_state", {31'b0, dbgState}, 32'h0);
      chk("t4_next_addr", bus.imem_addr, 32'h40);

      // Redirect with a full FIFO and stall released.
      latency = 0;
      do_reset();
      bus.stall = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) tick();
      bus.stall = 1'b0;
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h200;
      #1;
      chk("t5_req_off", {31'b0, bus.imem_req}, 32'h0);
      chk("t5_head_valid", {31'b0, bus.out_valid}, 32'h1);
      tick();
      bus.redirect = 1'b0;
      #1;
      chk("t5_flushed", {31'b0, bus.out_valid}, 32'h0);
      chk("t5_addr", bus.imem_addr, 32'h200);
      tick();
      chk("t5_pc", bus.out_pc, 32'h200);
      chk("t5_instr", bus.out_instr, 32'h0010_0293);
      tick();
      chk("t5_pc_next", bus.out_pc, 32'h204);

      // Asynchronous reset while in DISCARD.
      latency = 3;
      do_reset();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h80;
      #1;
      tick();
      bus.redirect = 1'b0;
      #1;
      tick();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h300;
      #1;
      tick();
      bus.redirect = 1'b0;
      #1;
      chk("t6_in_discard", {31'b0, dbgState}, 32'h1);
      #1;
      reset = 1'b0;
      #1;
      chk("t6_req", {31'b0, bus.imem_req}, 32'h0);
      chk("t6_state", {31'b0, dbgState}, 32'h0);
      chk("t6_instr", bus.out_instr, 32'h0000_0013);
      tick();
      reset = 1'b1;
      #1;
      chk("t6_restart_req", {31'b0, bus.imem_req}, 32'h1);
      chk("t6_restart_addr", bus.imem_addr, 32'h0);

      // PC wraps past 0xFFFF_FFFC; low redirect bits are dropped.
      latency = 0;
      do_reset();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFF;
      #1;
      tick();
      bus.redirect = 1'b0;
      #1;
      chk("t7_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("t7_addr_wrap", bus.imem_addr, 32'h0);
      chk("t7_pc_top", bus.out_pc, 32'hFFFF_FFFC);
      chk("t7_instr_top", bus.out_instr, 32'h0010_008F);
      tick();
      chk("t7_pc_wrap", bus.out_pc, 32'h0);
      chk("t7_instr_wrap", bus.out_instr, 32'h0010_0093);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
